e_clock_vpa_sync: RTL and testbench

- Upstream companion to the palcl glue PAL.
- Generates the 68000 6800-compatible E clock from the CPU clock, which feeds palcl's `e` input and the VIA/keyboard logic.
- Runs the synchronous (VPA) peripheral bus-cycle handshake: consumes palcl's `n_vpa`, produces `n_vma` and a cycle-termination strobe for the CPU model.
- Fully synchronous to the fast simulation clock. The CPU clock is treated as a sampled input.

---
 rtl/mac128_pkg.sv | 17 +
 rtl/e_divider.sv | 56 +++++
 rtl/e_clock_vpa_sync.sv | 110 +++++++++++
 tb/tb_e_clock_vpa_sync.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mac128_pkg.sv
// Shared types and constants for the E clock generator and the VPA handshake.
package mac128_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_VMA  = 2'd2,
    ST_TERM = 2'd3
  } vpa_state_e;

  localparam int unsigned E_PERIOD_MAX = 16;

  function automatic logic [3:0] ecnt_step(input logic [3:0] cnt, input logic [3:0] last);
    return (cnt == last) ? 4'd0 : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/e_divider.sv
// CPU clock edge detector and 6800 E clock divider.
// Strobes flag CPU rises that will produce an E rise or an E fall.
module e_divider
  import mac128_pkg::*;
#(
  parameter int unsigned E_LOW  = 6,
  parameter int unsigned E_HIGH = 4
) (
  input  logic       simclk_i,
  input  logic       res_i,
  input  logic       clock_i,
  output logic       crise_o,
  output logic       e_rise_next_o,
  output logic       e_fall_next_o,
  output logic       e_o,
  output logic [3:0] ecnt_o
);

  localparam logic [3:0] ELowC = 4'(E_LOW);
  localparam logic [3:0] LastC = 4'(E_LOW + E_HIGH - 1);

  logic       clk_q;
  logic [3:0] ecnt_q, ecnt_d, ecnt_next;
  logic       e_q, e_d;
  logic       crise;

  always_comb begin
    crise     = clock_i & ~clk_q;
    ecnt_next = ecnt_step(ecnt_q, LastC);
    ecnt_d    = ecnt_q;
    e_d       = e_q;
    if (crise) begin
      ecnt_d = ecnt_next;
      e_d    = (ecnt_next >= ELowC);
    end
  end

  always_ff @(posedge simclk_i or posedge res_i) begin
    if (res_i) begin
      clk_q  <= 1'b0;
      ecnt_q <= 4'd0;
      e_q    <= 1'b0;
    end else begin
      clk_q  <= clock_i;
      ecnt_q <= ecnt_d;
      e_q    <= e_d;
    end
  end

  assign crise_o       = crise;
  assign e_rise_next_o = crise & (ecnt_next == ELowC);
  assign e_fall_next_o = crise & (ecnt_next == 4'd0);
  assign e_o           = e_q;
  assign ecnt_o        = ecnt_q;

endmodule

// File: rtl/e_clock_vpa_sync.sv
// E clock generation plus the synchronous (VPA) peripheral cycle handshake:
// VMA asserts on a qualifying E rise, the cycle terminates on the following E fall.
module e_clock_vpa_sync
  import mac128_pkg::*;
#(
  parameter int unsigned E_LOW     = 6,
  parameter int unsigned E_HIGH    = 4,
  parameter int unsigned MIN_SETUP = 2
) (
  input  logic       simclk,
  input  logic       res,
  input  logic       clock,
  input  logic       n_as,
  input  logic       n_vpa,
  output logic       e,
  output logic       n_vma,
  output logic       n_vdtack,
  output logic [3:0] ecnt
);

  // Pre-increment setup count needed on the E-rise crise to allow VMA.
  localparam logic [3:0] SetupMinC = (MIN_SETUP == 0) ? 4'd0 : 4'(MIN_SETUP - 1);
  localparam logic [3:0] SetupSatC = 4'(MIN_SETUP);

  logic crise, e_rise_next, e_fall_next;

  vpa_state_e state_q, state_d;
  logic [3:0] setup_q, setup_d;
  logic       n_vma_q, n_vma_d;
  logic       n_vdtack_q, n_vdtack_d;

  e_divider #(
    .E_LOW (E_LOW),
    .E_HIGH(E_HIGH)
  ) u_e_divider (
    .simclk_i     (simclk),
    .res_i        (res),
    .clock_i      (clock),
    .crise_o      (crise),
    .e_rise_next_o(e_rise_next),
    .e_fall_next_o(e_fall_next),
    .e_o          (e),
    .ecnt_o       (ecnt)
  );

  always_comb begin
    state_d    = state_q;
    setup_d    = setup_q;
    n_vma_d    = n_vma_q;
    n_vdtack_d = n_vdtack_q;
    unique case (state_q)
      ST_IDLE: begin
        if (crise && !n_as && !n_vpa) begin
          state_d = ST_SYNC;
          setup_d = 4'd0;
        end
      end
      ST_SYNC: begin
        // Abort wins over any crise action in the same cycle.
        if (n_as) begin
          state_d = ST_IDLE;
          n_vma_d = 1'b1;
        end else if (crise) begin
          if (e_rise_next && (setup_q >= SetupMinC)) begin
            state_d = ST_VMA;
            n_vma_d = 1'b0;
          end
          if (setup_q < SetupSatC) begin
            setup_d = setup_q + 4'd1;
          end
        end
      end
      ST_VMA: begin
        if (n_as) begin
          state_d = ST_IDLE;
          n_vma_d = 1'b1;
        end else if (e_fall_next) begin
          state_d    = ST_TERM;
          n_vdtack_d = 1'b0;
        end
      end
      ST_TERM: begin
        if (n_as) begin
          state_d    = ST_IDLE;
          n_vma_d    = 1'b1;
          n_vdtack_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge simclk or posedge res) begin
    if (res) begin
      state_q    <= ST_IDLE;
      setup_q    <= 4'd0;
      n_vma_q    <= 1'b1;
      n_vdtack_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      setup_q    <= setup_d;
      n_vma_q    <= n_vma_d;
      n_vdtack_q <= n_vdtack_d;
    end
  end

  assign n_vma    = n_vma_q;
  assign n_vdtack = n_vdtack_q;

endmodule

// File: tb/tb_e_clock_vpa_sync.sv
// Bench for e_clock_vpa_sync: E waveform tracked against a CPU-rise count,
// n_vma/n_vdtack edges checked against a queue of expected edges.
module tb_e_clock_vpa_sync;

  logic       simclk = 1'b0;
  logic       res = 1'b1;
  logic       clock = 1'b0;
  logic       n_as = 1'b1;
  logic       n_vpa = 1'b1;
  logic       e, n_vma, n_vdtack;
  logic [3:0] ecnt;

  int n_tests = 0;
  int n_fail = 0;
  int ncr;

  typedef struct {
    int sig;   // 0: n_vma, 1: n_vdtack
    int val;
    int rise;  // CPU rise count at which the edge must be visible
  } ev_t;

  ev_t sb_q[$];

  e_clock_vpa_sync dut (
    .simclk  (simclk),
    .res     (res),
    .clock   (clock),
    .n_as    (n_as),
    .n_vpa   (n_vpa),
    .e       (e),
    .n_vma   (n_vma),
    .n_vdtack(n_vdtack),
    .ecnt    (ecnt)
  );

  always #2 simclk = ~simclk;

  initial begin
    #1;
    forever #32 clock = ~clock;
  end

  always @(posedge clock or posedge res) begin
    if (res) ncr <= 0;
    else     ncr <= ncr + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t rise=%0d)", tag, got, exp, $time, ncr);
    end
  endtask

  task automatic sb_push(input int sig, input int val, input int rise);
    ev_t ev;
    ev.sig  = sig;
    ev.val  = val;
    ev.rise = rise;
    sb_q.push_back(ev);
  endtask

  task automatic sb_pop(input int sig, input int val);
    ev_t ev;
    if (sb_q.size() == 0) begin
      check_eq("unexpected_edge", sig * 10 + val, -1);
    end else begin
      ev = sb_q.pop_front();
      check_eq("edge_signal", sig, ev.sig);
      check_eq("edge_value", val, ev.val);
      check_eq("edge_rise", ncr, ev.rise);
    end
  endtask

  task automatic wait_rise(input int n);
    int budget = 4000;
    @(negedge simclk);
    while (ncr < n && budget > 0) begin
      @(negedge simclk);
      budget--;
    end
    if (ncr < n) check_eq("wait_rise", ncr, n);
  endtask

  // Monitor: E divider against the rise count, output edges against the queue.
  initial begin
    logic prev_vma, prev_vdtack;
    prev_vma    = 1'b1;
    prev_vdtack = 1'b1;
    forever begin
      @(negedge simclk);
      if (res) begin
        prev_vma    = n_vma;
        prev_vdtack = n_vdtack;
      end else begin
        check_eq("ecnt", int'(ecnt), ncr % 10);
        check_eq("e", int'(e), ((ncr % 10) >= 6) ? 1 : 0);
        if (n_vma !== prev_vma) sb_pop(0, int'(n_vma));
        if (n_vdtack !== prev_vdtack) sb_pop(1, int'(n_vdtack));
        prev_vma    = n_vma;
        prev_vdtack = n_vdtack;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #10;
    check_eq("rst_e", int'(e), 0);
    check_eq("rst_n_vma", int'(n_vma), 1);
    check_eq("rst_n_vdtack", int'(n_vdtack), 1);
    check_eq("rst_ecnt", int'(ecnt), 0);
    #10;
    res = 1'b0;

    // Early VPA: recognised on rise 2, VMA at E rise 6, termination at wrap 10.
    wait_rise(1);
    n_as = 1'b0; n_vpa = 1'b0;
    sb_push(0, 0, 6);
    sb_push(1, 0, 10);
    wait_rise(11);
    sb_push(0, 1, 11);
    sb_push(1, 1, 11);
    n_as = 1'b1; n_vpa = 1'b1;

    // Late VPA: recognised on rise 15, too late for E rise 16, so VMA at 26.
    wait_rise(14);
    n_as = 1'b0; n_vpa = 1'b0;
    sb_push(0, 0, 26);
    sb_push(1, 0, 30);
    wait_rise(31);
    sb_push(0, 1, 31);
    sb_push(1, 1, 31);
    n_as = 1'b1; n_vpa = 1'b1;

    // Abort in SYNC: no output edges at all.
    wait_rise(32);
    n_as = 1'b0; n_vpa = 1'b0;
    wait_rise(34);
    n_as = 1'b1; n_vpa = 1'b1;

    // Reset while in VMA.
    wait_rise(41);
    n_as = 1'b0; n_vpa = 1'b0;
    sb_push(0, 0, 46);
    wait_rise(47);
    res = 1'b1;
    n_as = 1'b1; n_vpa = 1'b1;
    #1;
    check_eq("mid_rst_n_vma", int'(n_vma), 1);
    check_eq("mid_rst_n_vdtack", int'(n_vdtack), 1);
    check_eq("mid_rst_e", int'(e), 0);
    check_eq("mid_rst_ecnt", int'(ecnt), 0);
    @(negedge clock);
    @(negedge clock);
    #4;
    res = 1'b0;

    // Back-to-back cycles after the reset.
    wait_rise(1);
    n_as = 1'b0; n_vpa = 1'b0;
    sb_push(0, 0, 6);
    sb_push(1, 0, 10);
    wait_rise(11);
    sb_push(0, 1, 11);
    sb_push(1, 1, 11);
    n_as = 1'b1;
    @(negedge simclk);
    n_as = 1'b0;
    sb_push(0, 0, 16);
    sb_push(1, 0, 20);
    wait_rise(21);
    sb_push(0, 1, 21);
    sb_push(1, 1, 21);
    n_as = 1'b1; n_vpa = 1'b1;

    wait_rise(25);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
